// File: rtl/pll_rst_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// Holds the FSM state encoding, the relock counter width and the counter-width helper.
package pll_rst_pkg;

    typedef enum logic [1:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RUN
    } pll_rst_state_e;

    localparam int RELOCK_W = 8;

    // Width that holds every terminal count of the three sequencer intervals.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pll_rst_ctrl_if.sv
// Lock input and reset/status outputs of the PLL reset sequencer.
// master is the sequencer side; slave is the PLL/clock-manager and core side.
interface pll_rst_ctrl_if;
    import pll_rst_pkg::*;

    logic                locked_i;
    logic                pll_rstn_o;
    logic                rstn_o;
    logic                ready_o;
    logic [RELOCK_W-1:0] relock_cnt_o;

    modport master (
        input  locked_i,
        output pll_rstn_o,
        output rstn_o,
        output ready_o,
        output relock_cnt_o
    );

    modport slave (
        output locked_i,
        input  pll_rstn_o,
        input  rstn_o,
        input  ready_o,
        input  relock_cnt_o
    );

endinterface

// File: rtl/sync_bit.sv
// Single-bit flop-chain synchronizer with async active-low reset to 0.
// Latency STAGES edges; clr flushes the chain synchronously, no backpressure.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sh;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh <= '0;
        end else if (clr) begin
            sh <= '0;
        end else begin
            sh <= {sh[STAGES-2:0], d};
        end
    end

    assign q = sh[STAGES-1];

endmodule

// File: rtl/pll_rst_ctrl.sv
// PLL reset sequencer: PLL reset pulse, lock wait with retry, stable window, core reset release.
// Outputs registered from next state; core reset drops SYNC_STAGES+1 edges after lock loss.
module pll_rst_ctrl
    import pll_rst_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    pll_rst_ctrl_if.master    bus
);

    localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

    localparam logic [CW-1:0] PLL_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);

    pll_rst_state_e      state;
    pll_rst_state_e      state_nxt;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_nxt;
    logic                locked_s;
    logic                relock_inc;
    logic                pll_rstn_d;
    logic                rstn_d;
    logic                pll_rstn_q;
    logic                rstn_q;
    logic [RELOCK_W-1:0] relock_q;

    // The lock flag of a PLL held in reset is meaningless, so the chain is
    // flushed for as long as the PLL reset request is active.
    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk_i),
        .rstn (rstn_i),
        .clr  (~pll_rstn_q),
        .d    (bus.locked_i),
        .q    (locked_s)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= PLL_RST;
            cnt        <= '0;
            pll_rstn_q <= 1'b0;
            rstn_q     <= 1'b0;
            relock_q   <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pll_rstn_q <= pll_rstn_d;
            rstn_q     <= rstn_d;
            if (relock_inc && (relock_q != {RELOCK_W{1'b1}})) begin
                relock_q <= relock_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        relock_inc = 1'b0;
        unique case (state)
            PLL_RST: begin
                if (cnt == PLL_LAST) state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s)              state_nxt = STABLE;
                else if (cnt == TMO_LAST)  state_nxt = PLL_RST;
            end
            STABLE: begin
                if (!locked_s)             state_nxt = WAIT_LOCK;
                else if (cnt == STB_LAST)  state_nxt = RUN;
            end
            RUN: begin
                if (!locked_s) begin
                    state_nxt  = WAIT_LOCK;
                    relock_inc = 1'b1;
                end
            end
            default: state_nxt = PLL_RST;
        endcase

        // Counter is idle in RUN; every interval starts from zero on entry.
        if (state_nxt != state) begin
            cnt_nxt = '0;
        end else if (state == RUN) begin
            cnt_nxt = cnt;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end

        pll_rstn_d = (state_nxt != PLL_RST);
        rstn_d     = (state_nxt == RUN);
    end

    assign bus.pll_rstn_o   = pll_rstn_q;
    assign bus.rstn_o       = rstn_q;
    assign bus.ready_o      = rstn_q;
    assign bus.relock_cnt_o = relock_q;

endmodule
